// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
package icache_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {IDLE, FILL} state_t;

    // Address split, LSB first: byte offset, word offset, index, tag.
    function automatic word_t addr_woff(word_t a, int blkwords);
        return (a >> 2) & word_t'(blkwords - 1);
    endfunction

    function automatic word_t addr_idx(word_t a, int nsets, int blkwords);
        return (a >> (2 + $clog2(blkwords))) & word_t'(nsets - 1);
    endfunction

    function automatic word_t addr_tag(word_t a, int nsets, int blkwords);
        return a >> (2 + $clog2(blkwords) + $clog2(nsets));
    endfunction

    function automatic word_t blk_addr(word_t tag, word_t idx, word_t w, int nsets, int blkwords);
        int wb;
        int ib;
        wb = $clog2(blkwords);
        ib = $clog2(nsets);
        return (tag << (2 + wb + ib)) | ((idx & word_t'(nsets - 1)) << (2 + wb))
             | ((w & word_t'(blkwords - 1)) << 2);
    endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-set LRU ages plus victim selection (lowest invalid way, else the oldest way).
module icache_lru #(
    parameter  int NSETS = 8,
    parameter  int NWAYS = 2,
    localparam int IDXW  = $clog2(NSETS),
    localparam int WW    = (NWAYS > 1) ? $clog2(NWAYS) : 1
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             flush,
    input  logic             upd_en,
    input  logic             upd_inv,
    input  logic [IDXW-1:0]  upd_set,
    input  logic [WW-1:0]    upd_way,
    input  logic [IDXW-1:0]  q_set,
    input  logic [NWAYS-1:0] q_valid,
    output logic [WW-1:0]    victim
);
    logic [NWAYS-1:0][WW-1:0] age [NSETS];
    logic [WW-1:0] old_age;
    logic [WW-1:0] best;
    logic          found;

    // A freshly filled way counts as the oldest, so the valid ways of a set
    // always hold ages 0..k-1 in recency order.
    assign old_age = upd_inv ? WW'(NWAYS - 1) : age[upd_set][upd_way];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            for (int s = 0; s < NSETS; s++) age[s] <= '0;
        end else if (flush) begin
            for (int s = 0; s < NSETS; s++) age[s] <= '0;
        end else if (upd_en) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (WW'(w) == upd_way)
                    age[upd_set][w] <= '0;
                else if (age[upd_set][w] < old_age)
                    age[upd_set][w] <= age[upd_set][w] + WW'(1);
            end
        end
    end

    always_comb begin
        victim = '0;
        found  = 1'b0;
        best   = age[q_set][0];
        for (int w = 0; w < NWAYS; w++) begin
            if (!q_valid[w] && !found) begin
                victim = WW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 1; w < NWAYS; w++) begin
                if (age[q_set][w] > best) begin
                    best   = age[q_set][w];
                    victim = WW'(w);
                end
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with zero-cycle hits and
// in-order multi-word block fill.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int NSETS    = 8,
    parameter int NWAYS    = 2,
    parameter int BLKWORDS = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    input  logic  iflush,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  word_t iload,
    input  logic  iwait
);
    localparam int IDXW  = $clog2(NSETS);
    localparam int WOFFW = $clog2(BLKWORDS);
    localparam int CW    = (BLKWORDS > 1) ? WOFFW : 1;
    localparam int WW    = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int TAGW  = 30 - WOFFW - IDXW;

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
    } tagent_t;

    tagent_t tags [NSETS][NWAYS];
    word_t   data [NSETS][NWAYS][BLKWORDS];

    state_t           state, state_n;
    logic [TAGW-1:0]  tag, l_tag;
    logic [IDXW-1:0]  idx, l_idx;
    logic [CW-1:0]    woff, cnt;
    logic [WW-1:0]    hway, l_way, victim;
    logic [NWAYS-1:0] setv;
    logic             hit, miss, xfer, fill_done;

    assign tag  = TAGW'(addr_tag(imemaddr, NSETS, BLKWORDS));
    assign idx  = IDXW'(addr_idx(imemaddr, NSETS, BLKWORDS));
    assign woff = CW'(addr_woff(imemaddr, BLKWORDS));

    always_comb begin
        setv = '0;
        hit  = 1'b0;
        hway = '0;
        for (int w = 0; w < NWAYS; w++) begin
            setv[w] = tags[idx][w].valid;
            if (setv[w] && tags[idx][w].tag == tag && !hit) begin
                hit  = 1'b1;
                hway = WW'(w);
            end
        end
    end

    always_comb begin
        state_n   = state;
        ihit      = 1'b0;
        miss      = 1'b0;
        imemload  = '0;
        iREN      = 1'b0;
        iaddr     = '0;
        xfer      = 1'b0;
        fill_done = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN && !iflush && hit;
                miss = imemREN && !iflush && !hit;
                if (ihit) imemload = data[idx][hway][woff];
                if (miss) state_n = FILL;
            end
            FILL: begin
                iREN      = 1'b1;
                iaddr     = blk_addr(word_t'(l_tag), word_t'(l_idx), word_t'(cnt), NSETS, BLKWORDS);
                xfer      = !iwait && !iflush;
                fill_done = xfer && (cnt == CW'(BLKWORDS - 1));
                if (iflush || fill_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            l_tag <= '0;
            l_idx <= '0;
            l_way <= '0;
            cnt   <= '0;
            for (int s = 0; s < NSETS; s++)
                for (int w = 0; w < NWAYS; w++) tags[s][w] <= '0;
        end else begin
            state <= state_n;
            if (miss) begin
                l_tag <= tag;
                l_idx <= idx;
                l_way <= victim;
                cnt   <= '0;
            end
            if (xfer) cnt <= cnt + CW'(1);
            // The line only turns valid once every word has landed.
            if (iflush) begin
                for (int s = 0; s < NSETS; s++)
                    for (int w = 0; w < NWAYS; w++) tags[s][w].valid <= 1'b0;
            end else if (fill_done) begin
                tags[l_idx][l_way] <= '{valid: 1'b1, tag: l_tag};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (xfer) data[l_idx][l_way][cnt] <= iload;
    end

    icache_lru #(.NSETS(NSETS), .NWAYS(NWAYS)) u_lru (
        .gclk    (CLK),
        .grst_n  (nRST),
        .flush   (iflush),
        .upd_en  (ihit || fill_done),
        .upd_inv (fill_done),
        .upd_set (ihit ? idx : l_idx),
        .upd_way (ihit ? hway : l_way),
        .q_set   (idx),
        .q_valid (setv),
        .victim  (victim)
    );

endmodule
